// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types and the RAM responder's default configuration.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    localparam int    RAM_LAT      = 2;
    localparam int    RAM_DEPTH_W  = 10;
    localparam word_t RAM_ERR_WORD = 32'hBAD1BAD1;

    // Which source currently drives ramload.
    typedef enum logic [1:0] {LOAD_ZERO, LOAD_RAM, LOAD_ERR} load_src_t;
endpackage

// File: rtl/ram_responder_if.sv
// Memory controller <-> RAM responder handshake bundle.
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (output ramREN, ramWEN, ramaddr, ramstore,
                    input  ramload, ramstate);
    modport slave  (input  ramREN, ramWEN, ramaddr, ramstore,
                    output ramload, ramstate);
endinterface

// File: rtl/ram_storage.sv
// Single-port synchronous word array; read data registered on re. No reset.
module ram_storage
    import cpu_types_pkg::*;
#(
    parameter int DEPTH_W = RAM_DEPTH_W
) (
    input  logic               CLK,
    input  logic               we,
    input  logic               re,
    input  logic [DEPTH_W-1:0] addr,
    input  word_t              wdata,
    output word_t              rdata
);
    word_t mem [2**DEPTH_W];

    always_ff @(posedge CLK) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/ram_responder.sv
// Latency-modelled RAM answering ramREN/ramWEN with FREE/BUSY/ACCESS/ERROR.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT     = RAM_LAT,
    parameter int DEPTH_W = RAM_DEPTH_W
) (
    input logic       CLK,
    input logic       RST,
    ram_responder_if.slave ram
);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LAT > 0) ? CNT_W'(LAT - 1) : '0;

    ramstate_t        st, st_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             lat_wen, lat_wen_nx;
    word_t            lat_addr, lat_addr_nx, lat_store, lat_store_nx;
    load_src_t        src, src_nx;
    logic             acc_we, acc_re;
    word_t            rdata;

    logic req, viol, diff;
    assign req  = ram.ramREN | ram.ramWEN;
    assign viol = (ram.ramREN & ram.ramWEN) || (ram.ramaddr[1:0] != 2'b00) ||
                  ((ram.ramaddr >> (DEPTH_W + 2)) != '0);
    assign diff = (ram.ramWEN != lat_wen) || (ram.ramaddr != lat_addr) ||
                  (ram.ramstore != lat_store);

    always_comb begin
        st_nx        = st;
        cnt_nx       = cnt;
        lat_wen_nx   = lat_wen;
        lat_addr_nx  = lat_addr;
        lat_store_nx = lat_store;
        src_nx       = src;
        acc_we       = 1'b0;
        acc_re       = 1'b0;
        case (st)
            // ACCESS is a one-cycle pulse; a held request starts afresh.
            FREE, ACCESS: begin
                st_nx = FREE;
                if (req) begin
                    if (viol) begin
                        st_nx  = ERROR;
                        src_nx = LOAD_ERR;
                    end else if (LAT == 0) begin
                        st_nx  = ACCESS;
                        acc_we = ram.ramWEN;
                        acc_re = ~ram.ramWEN;
                        if (!ram.ramWEN) src_nx = LOAD_RAM;
                    end else begin
                        st_nx        = BUSY;
                        cnt_nx       = CNT_INIT;
                        lat_wen_nx   = ram.ramWEN;
                        lat_addr_nx  = ram.ramaddr;
                        lat_store_nx = ram.ramstore;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    st_nx = FREE;
                end else if (diff) begin
                    cnt_nx       = CNT_INIT;
                    lat_wen_nx   = ram.ramWEN;
                    lat_addr_nx  = ram.ramaddr;
                    lat_store_nx = ram.ramstore;
                end else if (viol) begin
                    st_nx  = ERROR;
                    src_nx = LOAD_ERR;
                end else if (cnt == '0) begin
                    // Inputs equal the latched request here, so use them directly.
                    st_nx  = ACCESS;
                    acc_we = ram.ramWEN;
                    acc_re = ~ram.ramWEN;
                    if (!ram.ramWEN) src_nx = LOAD_RAM;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: st_nx = FREE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st        <= FREE;
            cnt       <= '0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_store <= '0;
            src       <= LOAD_ZERO;
        end else begin
            st        <= st_nx;
            cnt       <= cnt_nx;
            lat_wen   <= lat_wen_nx;
            lat_addr  <= lat_addr_nx;
            lat_store <= lat_store_nx;
            src       <= src_nx;
        end
    end

    ram_storage #(.DEPTH_W(DEPTH_W)) u_storage (
        .CLK   (CLK),
        .we    (acc_we & ~RST),
        .re    (acc_re & ~RST),
        .addr  (ram.ramaddr[DEPTH_W+1:2]),
        .wdata (ram.ramstore),
        .rdata (rdata)
    );

    always_comb begin
        ram.ramload = '0;
        case (src)
            LOAD_RAM: ram.ramload = rdata;
            LOAD_ERR: ram.ramload = RAM_ERR_WORD;
            default:  ram.ramload = '0;
        endcase
    end

    assign ram.ramstate = st;
endmodule
